// File: rtl/vec_cache_rd_req_rob.sv
// West-edge read initiator with in-order reorder buffer for one vec_cache bank-row lane.
// Optional unexpected-response checker: define VEC_CACHE_ROB_ERR_CHK_EN.

package vec_cache_rob_pkg;
    parameter int TXN_W = 8;

    typedef struct packed {
        logic [TXN_W-1:0] txn_id;
        logic [2:0]       lane;
        logic [31:0]      addr;
    } arb_out_req_t;

    typedef struct packed {
        logic [TXN_W-1:0] txn_id;
        logic [63:0]      data;
    } data_pld_t;
endpackage

module vec_cache_rd_req_rob
    import vec_cache_rob_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int LANE_ID = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_vld,
    input  arb_out_req_t             req_pld,
    output logic                     req_rdy,
    output logic                     rd_cmd_vld,
    output arb_out_req_t             rd_cmd_pld,
    input  logic                     rsp_vld,
    input  data_pld_t                rsp_pld,
    output logic                     out_vld,
    output data_pld_t                out_pld,
    input  logic                     out_rdy,
    output logic [$clog2(DEPTH):0]   outstanding_cnt,
    output logic                     err_unexp
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    data_pld_t        mem_q [DEPTH];
    arb_out_req_t     cmd_pld_q, cmd_pld_d;
    logic             cmd_vld_q, cmd_vld_d;

    logic [PW-1:0] cnt;
    logic          full;
    logic          alloc;
    logic          retire;
    logic          cap;
    logic          rsp_ok;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] rsp_idx;

    assign cnt     = wr_ptr_q - rd_ptr_q;
    assign full    = (cnt == PW'(DEPTH));
    assign req_rdy = !full;
    assign wr_idx  = wr_ptr_q[IW-1:0];
    assign rd_idx  = rd_ptr_q[IW-1:0];
    assign rsp_idx = rsp_pld.txn_id[IW-1:0];

    assign alloc   = req_vld && req_rdy;
    assign out_vld = filled_q[rd_idx];
    assign out_pld = mem_q[rd_idx];
    assign retire  = out_vld && out_rdy;
    assign cap     = rsp_vld && rsp_ok;

    assign rd_cmd_vld      = cmd_vld_q;
    assign rd_cmd_pld      = cmd_pld_q;
    assign outstanding_cnt = cnt;

`ifdef VEC_CACHE_ROB_ERR_CHK_EN
    logic [IW-1:0] rsp_off;
    logic          err_q, err_d;

    // Tag is live iff its distance from the head is below the occupancy.
    assign rsp_off   = rsp_idx - rd_idx;
    assign rsp_ok    = ({1'b0, rsp_off} < cnt) && !filled_q[rsp_idx];
    assign err_d     = rsp_vld && !rsp_ok;
    assign err_unexp = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign rsp_ok    = 1'b1;
    assign err_unexp = 1'b0;
`endif

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        filled_d  = filled_q;
        cmd_pld_d = cmd_pld_q;
        cmd_vld_d = alloc;
        if (alloc) begin
            cmd_pld_d        = req_pld;
            cmd_pld_d.txn_id = TXN_W'(wr_idx);
            cmd_pld_d.lane   = 3'(LANE_ID);
            wr_ptr_d         = wr_ptr_q + PW'(1);
            filled_d[wr_idx] = 1'b0;
        end
        if (retire) begin
            filled_d[rd_idx] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PW'(1);
        end
        // Capture last so a legal response always wins over stale clears.
        if (cap) begin
            filled_d[rsp_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            filled_q  <= '0;
            cmd_pld_q <= '0;
            cmd_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            filled_q  <= filled_d;
            cmd_pld_q <= cmd_pld_d;
            cmd_vld_q <= cmd_vld_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (cap) begin
            mem_q[rsp_idx] <= rsp_pld;
        end
    end

endmodule

// File: tb/tb_vec_cache_rd_req_rob.sv
// Directed bench for vec_cache_rd_req_rob: vector table plus multi-cycle corner sequences.
module tb_vec_cache_rd_req_rob;
    import vec_cache_rob_pkg::*;

    localparam int DEPTH = 16;
    localparam int LANE  = 3;
`ifdef VEC_CACHE_ROB_ERR_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_vld = 1'b0;
    arb_out_req_t req_pld = '0;
    logic         req_rdy;
    logic         rd_cmd_vld;
    arb_out_req_t rd_cmd_pld;
    logic         rsp_vld = 1'b0;
    data_pld_t    rsp_pld = '0;
    logic         out_vld;
    data_pld_t    out_pld;
    logic         out_rdy = 1'b0;
    logic [4:0]   outstanding_cnt;
    logic         err_unexp;

    int n_cmp = 0;
    int n_err = 0;

    vec_cache_rd_req_rob #(.DEPTH(DEPTH), .LANE_ID(LANE)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_pld(req_pld), .req_rdy(req_rdy),
        .rd_cmd_vld(rd_cmd_vld), .rd_cmd_pld(rd_cmd_pld),
        .rsp_vld(rsp_vld), .rsp_pld(rsp_pld),
        .out_vld(out_vld), .out_pld(out_pld), .out_rdy(out_rdy),
        .outstanding_cnt(outstanding_cnt), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req_v;
        logic [31:0] addr;
        logic        rsp_v;
        logic [7:0]  tag;
        logic [63:0] data;
        logic        ordy;
        logic        e_cmd_v;
        logic [7:0]  e_txn;
        logic        e_ov;
        logic [63:0] e_od;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t tv [13];

    function automatic vec_t mk(logic rv, logic [31:0] a, logic sv, logic [7:0] t,
                                logic [63:0] d, logic ordy, logic ecv, logic [7:0] etx,
                                logic eov, logic [63:0] eod, logic [4:0] ecnt);
        vec_t v;
        v.req_v = rv; v.addr = a; v.rsp_v = sv; v.tag = t; v.data = d; v.ordy = ordy;
        v.e_cmd_v = ecv; v.e_txn = etx; v.e_ov = eov; v.e_od = eod; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_vld = 1'b0; rsp_vld = 1'b0; out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_req(input logic v, input logic [31:0] a);
        req_vld = v;
        req_pld.txn_id = 8'hEE;
        req_pld.lane   = 3'(LANE);
        req_pld.addr   = a;
    endtask

    task automatic drive_rsp(input logic v, input logic [7:0] t, input logic [63:0] d);
        rsp_vld = v;
        rsp_pld.txn_id = t;
        rsp_pld.data   = d;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_rdy"},  64'(req_rdy), 64'd1);
        chk({tag, "_cmd_vld"},  64'(rd_cmd_vld), 64'd0);
        chk({tag, "_cmd_pld"},  64'(rd_cmd_pld), 64'd0);
        chk({tag, "_out_vld"},  64'(out_vld), 64'd0);
        chk({tag, "_out_pld"},  64'(out_pld.data), 64'd0);
        chk({tag, "_cnt"},      64'(outstanding_cnt), 64'd0);
        chk({tag, "_err"},      64'(err_unexp), 64'd0);
    endtask

    initial begin
        // Issue 4, return 3,1,0,2, drain in order; step 9 allocates and retires together.
        tv[0]  = mk(1, 32'h1000, 0, 8'd0, 64'h0,  0, 1, 8'd0, 0, 64'h0,  5'd1);
        tv[1]  = mk(1, 32'h1004, 0, 8'd0, 64'h0,  0, 1, 8'd1, 0, 64'h0,  5'd2);
        tv[2]  = mk(1, 32'h1008, 0, 8'd0, 64'h0,  0, 1, 8'd2, 0, 64'h0,  5'd3);
        tv[3]  = mk(1, 32'h100C, 0, 8'd0, 64'h0,  0, 1, 8'd3, 0, 64'h0,  5'd4);
        tv[4]  = mk(0, 32'h0,    1, 8'd3, 64'hD3, 1, 0, 8'd0, 0, 64'h0,  5'd4);
        tv[5]  = mk(0, 32'h0,    1, 8'd1, 64'hD1, 1, 0, 8'd0, 0, 64'h0,  5'd4);
        tv[6]  = mk(0, 32'h0,    1, 8'd0, 64'hD0, 1, 0, 8'd0, 1, 64'hD0, 5'd4);
        tv[7]  = mk(0, 32'h0,    0, 8'd0, 64'h0,  1, 0, 8'd0, 1, 64'hD1, 5'd3);
        tv[8]  = mk(0, 32'h0,    1, 8'd2, 64'hD2, 1, 0, 8'd0, 1, 64'hD2, 5'd2);
        tv[9]  = mk(1, 32'h1010, 0, 8'd0, 64'h0,  1, 1, 8'd4, 1, 64'hD3, 5'd2);
        tv[10] = mk(0, 32'h0,    0, 8'd0, 64'h0,  1, 0, 8'd0, 0, 64'h0,  5'd1);
        tv[11] = mk(0, 32'h0,    1, 8'd4, 64'hD4, 0, 0, 8'd0, 1, 64'hD4, 5'd1);
        tv[12] = mk(0, 32'h0,    0, 8'd0, 64'h0,  1, 0, 8'd0, 0, 64'h0,  5'd0);

        do_reset();
        chk_reset_vals("rst0");

        for (int i = 0; i < 13; i++) begin
            drive_req(tv[i].req_v, tv[i].addr);
            drive_rsp(tv[i].rsp_v, tv[i].tag, tv[i].data);
            out_rdy = tv[i].ordy;
            tick();
            chk($sformatf("v%0d_cmd_vld", i), 64'(rd_cmd_vld), 64'(tv[i].e_cmd_v));
            if (tv[i].e_cmd_v) begin
                chk($sformatf("v%0d_txn", i),  64'(rd_cmd_pld.txn_id), 64'(tv[i].e_txn));
                chk($sformatf("v%0d_addr", i), 64'(rd_cmd_pld.addr), 64'(tv[i].addr));
                chk($sformatf("v%0d_lane", i), 64'(rd_cmd_pld.lane), 64'(LANE));
            end
            chk($sformatf("v%0d_out_vld", i), 64'(out_vld), 64'(tv[i].e_ov));
            if (tv[i].e_ov)
                chk($sformatf("v%0d_out_data", i), 64'(out_pld.data), tv[i].e_od);
            chk($sformatf("v%0d_cnt", i), 64'(outstanding_cnt), 64'(tv[i].e_cnt));
            chk($sformatf("v%0d_req_rdy", i), 64'(req_rdy), 64'd1);
        end
        drive_req(0, 0); drive_rsp(0, 0, 0); out_rdy = 1'b0;

        // Fill to DEPTH, refuse one more, free one, then wrap tag 0.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive_req(1, 32'h2000 + 32'(i));
            tick();
            chk($sformatf("full_txn%0d", i), 64'(rd_cmd_pld.txn_id), 64'(i));
            chk($sformatf("full_vld%0d", i), 64'(rd_cmd_vld), 64'd1);
        end
        chk("full_req_rdy", 64'(req_rdy), 64'd0);
        chk("full_cnt", 64'(outstanding_cnt), 64'd16);
        tick();
        chk("full_blocked_vld", 64'(rd_cmd_vld), 64'd0);
        chk("full_blocked_cnt", 64'(outstanding_cnt), 64'd16);
        drive_req(0, 0);
        drive_rsp(1, 8'd0, 64'hA0);
        tick();
        drive_rsp(0, 0, 0);
        chk("full_head_vld", 64'(out_vld), 64'd1);
        out_rdy = 1'b1;
        #1;
        chk("full_rdy_same_cycle", 64'(req_rdy), 64'd0);
        tick();
        out_rdy = 1'b0;
        chk("full_rdy_next_cycle", 64'(req_rdy), 64'd1);
        chk("full_cnt_after_retire", 64'(outstanding_cnt), 64'd15);
        drive_req(1, 32'h3000);
        tick();
        drive_req(0, 0);
        chk("wrap_vld", 64'(rd_cmd_vld), 64'd1);
        chk("wrap_txn", 64'(rd_cmd_pld.txn_id), 64'd0);
        chk("wrap_addr", 64'(rd_cmd_pld.addr), 64'h3000);
        chk("wrap_cnt", 64'(outstanding_cnt), 64'd16);

        // Backpressure: three filled entries held, then drained back to back.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_req(1, 32'h4000 + 32'(i));
            tick();
        end
        drive_req(0, 0);
        drive_rsp(1, 8'd2, 64'hB2); tick();
        drive_rsp(1, 8'd0, 64'hB0); tick();
        drive_rsp(1, 8'd1, 64'hB1); tick();
        drive_rsp(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold%0d_vld", i), 64'(out_vld), 64'd1);
            chk($sformatf("hold%0d_data", i), 64'(out_pld.data), 64'hB0);
        end
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain%0d_vld", k), 64'(out_vld), 64'd1);
            chk($sformatf("drain%0d_data", k), 64'(out_pld.data), 64'hB0 + 64'(k));
            tick();
        end
        out_rdy = 1'b0;
        chk("drain_done_vld", 64'(out_vld), 64'd0);
        chk("drain_done_cnt", 64'(outstanding_cnt), 64'd0);

        // Response for a tag that was never issued.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive_req(1, 32'h5000 + 32'(i));
            tick();
        end
        drive_req(0, 0);
        drive_rsp(1, 8'd5, 64'hC5);
        tick();
        drive_rsp(0, 0, 0);
        chk("unexp_err", 64'(err_unexp), 64'(EXP_ERR));
        chk("unexp_out_vld", 64'(out_vld), 64'd0);
        chk("unexp_cnt", 64'(outstanding_cnt), 64'd2);
        tick();
        chk("unexp_err_pulse", 64'(err_unexp), 64'd0);

        // Asynchronous reset with three outstanding, then a stale response.
        drive_req(1, 32'h5008);
        tick();
        drive_req(0, 0);
        chk("pre_rst_cnt", 64'(outstanding_cnt), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async");
        tick();
        rst = 1'b0;
        drive_rsp(1, 8'd1, 64'hC1);
        tick();
        drive_rsp(0, 0, 0);
        chk("late_err", 64'(err_unexp), 64'(EXP_ERR));
        chk("late_out_vld", 64'(out_vld), 64'd0);
        chk("late_cnt", 64'(outstanding_cnt), 64'd0);
        tick();
        chk("late_out_vld2", 64'(out_vld), 64'd0);
        chk("late_err2", 64'(err_unexp), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
